// File: rtl/stage_seq_ctrl_if.sv
// Control/status bundle between the host/debug pins, the stage sequencer
// and the datapath stage registers.
interface stage_seq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             step;
  logic             halt_req;
  logic             mem_wait;
  logic             en_ft;
  logic             en_dc;
  logic             en_ex;
  logic             en_wb;
  logic             adv;
  logic             busy;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] instr_cnt;
  logic [2:0]       state;

  modport master (
    output run, step, halt_req, mem_wait,
    input  en_ft, en_dc, en_ex, en_wb, adv, busy, halted, err, instr_cnt, state
  );

  modport slave (
    input  run, step, halt_req, mem_wait,
    output en_ft, en_dc, en_ex, en_wb, adv, busy, halted, err, instr_cnt, state
  );
endinterface

// File: rtl/stage_seq_ctrl.sv
// Four-phase FT/DC/EX/WB instruction sequencer for the 15-bit CPU with
// run/step/halt control, memory-wait stalls and a wait-timeout error trap.
module stage_seq_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input logic             clk,
  input logic             rst_n,
  stage_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FT    = 3'd1,
    S_DC    = 3'd2,
    S_EX    = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       wait_q;
  logic [7:0]       wait_d;
  logic [CNT_W-1:0] cnt_q;
  logic             step_mode_q;
  logic             step_mode_d;
  logic             halt_q;
  logic             halt_d;
  logic             step_q;
  logic             en_ft_q;
  logic             en_dc_q;
  logic             en_ex_q;
  logic             en_wb_q;
  logic             busy_q;
  logic             halted_q;
  logic             err_q;
  logic             cnt_inc;
  logic             wait_bump;
  logic             step_edge;
  logic             in_busy;

  assign step_edge = bus.step & ~step_q;
  assign in_busy   = (state_q == S_FT) | (state_q == S_DC) |
                     (state_q == S_EX) | (state_q == S_WB);

  // Next-state, wait-counter and halt-latch decisions
  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    cnt_inc     = 1'b0;
    wait_bump   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d     = S_FT;
          step_mode_d = 1'b0;
        end else if (step_edge) begin
          state_d     = S_FT;
          step_mode_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FT, S_EX: begin
        if (!bus.mem_wait) begin
          state_d = (state_q == S_FT) ? S_DC : S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_bump = 1'b1;
        end
      end
      S_DC: state_d = S_EX;
      S_WB: begin
        cnt_inc = 1'b1;
        // A HALT flagged in the write-back cycle itself still stops here
        if (halt_q || bus.halt_req) begin
          state_d = S_HALT;
        end else if (step_mode_q || !bus.run) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FT;
        end
      end
      S_HALT: begin
        if (!bus.run) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HALT;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (wait_bump) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end

    if ((state_d == S_FT) && (state_q != S_FT)) begin
      halt_d = 1'b0;
    end else if (in_busy && bus.halt_req) begin
      halt_d = 1'b1;
    end else begin
      halt_d = halt_q;
    end
  end

  // State, counters and registered Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_q      <= 8'd0;
      cnt_q       <= '0;
      step_mode_q <= 1'b0;
      halt_q      <= 1'b0;
      step_q      <= 1'b0;
      en_ft_q     <= 1'b0;
      en_dc_q     <= 1'b0;
      en_ex_q     <= 1'b0;
      en_wb_q     <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      step_mode_q <= step_mode_d;
      halt_q      <= halt_d;
      step_q      <= bus.step;
      if (cnt_inc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= cnt_q;
      end
      en_ft_q  <= (state_d == S_FT);
      en_dc_q  <= (state_d == S_DC);
      en_ex_q  <= (state_d == S_EX);
      en_wb_q  <= (state_d == S_WB);
      busy_q   <= (state_d == S_FT) | (state_d == S_DC) |
                  (state_d == S_EX) | (state_d == S_WB);
      halted_q <= (state_d == S_HALT);
      err_q    <= (state_d == S_ERROR);
    end
  end

  assign bus.en_ft     = en_ft_q;
  assign bus.en_dc     = en_dc_q;
  assign bus.en_ex     = en_ex_q;
  assign bus.en_wb     = en_wb_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.err       = err_q;
  assign bus.instr_cnt = cnt_q;
  assign bus.state     = state_q;
  assign bus.adv       = busy_q & ~(bus.mem_wait & (en_ft_q | en_ex_q));

endmodule

// File: tb/tb_stage_seq_ctrl.sv
// Bench for stage_seq_ctrl: two parameterisations driven by the same stimulus,
// each checked every cycle against an instruction-level reference model.
module tb_stage_seq_ctrl;

  localparam int CW_A = 16;
  localparam int WM_A = 15;
  localparam int CW_B = 2;
  localparam int WM_B = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic run = 1'b0;
  logic step = 1'b0;
  logic halt_req = 1'b0;
  logic mem_wait = 1'b0;

  always #5 clk = ~clk;

  stage_seq_ctrl_if #(.CNT_W(CW_A)) ifa ();
  stage_seq_ctrl_if #(.CNT_W(CW_B)) ifb ();

  assign ifa.run = run;  assign ifa.step = step;
  assign ifa.halt_req = halt_req;  assign ifa.mem_wait = mem_wait;
  assign ifb.run = run;  assign ifb.step = step;
  assign ifb.halt_req = halt_req;  assign ifb.mem_wait = mem_wait;

  stage_seq_ctrl #(.CNT_W(CW_A), .WAIT_MAX(WM_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  stage_seq_ctrl #(.CNT_W(CW_B), .WAIT_MAX(WM_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // Instruction-level view: in an instruction or not, which of its 4 phases,
  // stall length so far, and the sticky halted/error conditions.
  typedef struct {
    bit busy;
    int phase;
    int waits;
    bit halted;
    bit error;
    bit step_mode;
    bit halt_pend;
    int count;
    bit step_prev;
  } mdl_t;

  mdl_t ma;
  mdl_t mb;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '{default: 0};
    return r;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, bit run_i, bit step_i, bit hreq, bit mw,
                                    int modn, int wmax);
    mdl_t r;
    bit   edge_i;
    r = m;
    edge_i = step_i && !m.step_prev;
    r.step_prev = step_i;
    if (m.error) return r;
    if (m.busy && hreq) r.halt_pend = 1'b1;
    if (m.halted) begin
      if (!run_i) r.halted = 1'b0;
    end else if (!m.busy) begin
      if (run_i || edge_i) begin
        r.busy = 1'b1; r.phase = 0; r.waits = 0;
        r.step_mode = !run_i; r.halt_pend = 1'b0;
      end
    end else if (m.phase == 1) begin
      r.phase = 2;
    end else if (m.phase == 3) begin
      r.count = (m.count + 1) % modn;
      if (m.halt_pend || hreq) begin
        r.busy = 1'b0; r.halted = 1'b1;
      end else if (m.step_mode || !run_i) begin
        r.busy = 1'b0;
      end else begin
        r.phase = 0; r.halt_pend = 1'b0;
      end
    end else if (!mw) begin
      r.phase = m.phase + 1; r.waits = 0;
    end else if (m.waits + 1 >= wmax) begin
      r.busy = 1'b0; r.error = 1'b1;
    end else begin
      r.waits = m.waits + 1;
    end
    return r;
  endfunction

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic chk_model(input string who, input logic [2:0] st, input logic [3:0] en,
                           input logic adv, input logic busy, input logic halted,
                           input logic err, input logic [31:0] cnt, input mdl_t m);
    int         st_e;
    logic [3:0] en_e;
    st_e = m.error ? 6 : m.halted ? 5 : m.busy ? m.phase + 1 : 0;
    en_e = m.busy ? 4'(1 << m.phase) : 4'b0000;
    chk_val({who, "_state"}, 32'(st), 32'(st_e));
    chk_val({who, "_en"}, 32'(en), 32'(en_e));
    chk_val({who, "_adv"}, 32'(adv),
            32'(m.busy && !(mem_wait && (m.phase == 0 || m.phase == 2))));
    chk_val({who, "_busy"}, 32'(busy), 32'(m.busy));
    chk_val({who, "_halted"}, 32'(halted), 32'(m.halted));
    chk_val({who, "_err"}, 32'(err), 32'(m.error));
    chk_val({who, "_cnt"}, cnt, 32'(m.count));
  endtask

  task automatic check_all();
    chk_model("a", ifa.state, {ifa.en_wb, ifa.en_ex, ifa.en_dc, ifa.en_ft}, ifa.adv,
              ifa.busy, ifa.halted, ifa.err, 32'(ifa.instr_cnt), ma);
    chk_model("b", ifb.state, {ifb.en_wb, ifb.en_ex, ifb.en_dc, ifb.en_ft}, ifb.adv,
              ifb.busy, ifb.halted, ifb.err, 32'(ifb.instr_cnt), mb);
  endtask

  // Inputs are set at the falling edge, sampled at the rising edge, outputs checked at the next fall
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      ma = mdl_next(ma, run, step, halt_req, mem_wait, 1 << CW_A, WM_A);
      mb = mdl_next(mb, run, step, halt_req, mem_wait, 1 << CW_B, WM_B);
      @(negedge clk);
      check_all();
    end
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 ma = mdl_reset();
    mb = mdl_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int burst;
    rst_n = 1'b1;
    ma = mdl_reset();
    mb = mdl_reset();
    #1 rst_n = 1'b0;
    #2 check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Free run: four back-to-back instructions, no idle gaps
    run = 1'b1;
    ticks(17);
    chk_val("run16_cnt", 32'(ifa.instr_cnt), 32'd4);
    chk_val("run16_state", 32'(ifa.state), 32'd1);
    run = 1'b0;
    ticks(4);

    // Single step; the second pulse inside the pass is dropped
    do_reset();
    step = 1'b1; ticks(1);
    chk_val("step_ft", 32'(ifa.state), 32'd1);
    step = 1'b0; ticks(1);
    step = 1'b1; ticks(1);
    step = 1'b0; ticks(5);
    chk_val("step_cnt", 32'(ifa.instr_cnt), 32'd1);
    chk_val("step_idle", 32'(ifa.busy), 32'd0);

    // Three wait cycles in FT stretch the instruction to 7 cycles; wait in DC ignored
    do_reset();
    run = 1'b1; ticks(1);
    mem_wait = 1'b1; ticks(3);
    chk_val("wait_ft_held", 32'(ifa.en_ft), 32'd1);
    mem_wait = 1'b0; ticks(1);
    mem_wait = 1'b1; ticks(1);
    chk_val("wait_dc_ignored", 32'(ifa.state), 32'd3);
    mem_wait = 1'b0; ticks(2);
    chk_val("wait_cnt", 32'(ifa.instr_cnt), 32'd1);

    // HALT flagged during DC
    do_reset();
    run = 1'b1; ticks(2);
    halt_req = 1'b1; ticks(1);
    halt_req = 1'b0; ticks(2);
    chk_val("halt_state", 32'(ifa.state), 32'd5);
    chk_val("halt_cnt", 32'(ifa.instr_cnt), 32'd1);
    ticks(3);
    run = 1'b0; ticks(1);
    chk_val("halt_exit", 32'(ifa.state), 32'd0);

    // Wait timeout in EX
    do_reset();
    run = 1'b1; ticks(3);
    mem_wait = 1'b1; ticks(14);
    chk_val("wait14_ex", 32'(ifa.state), 32'd3);
    ticks(1);
    chk_val("timeout_err", 32'(ifa.err), 32'd1);
    mem_wait = 1'b0; run = 1'b0; step = 1'b1; ticks(3);
    chk_val("err_sticky", 32'(ifa.state), 32'd6);
    step = 1'b0;

    // Narrow counter wraps; RUN dropped in EX lets the last instruction finish
    do_reset();
    run = 1'b1; ticks(1);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        ticks(2);
        run = 1'b0;
        ticks(2);
      end else begin
        ticks(4);
      end
      chk_val("wrap_cnt", 32'(ifb.instr_cnt), 32'((i + 1) % 4));
    end
    chk_val("wrap_idle", 32'(ifb.state), 32'd0);

    // Randomized traffic against the model
    burst = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(149, 0) == 0) do_reset();
      if ($urandom_range(19, 0) == 0) run = ~run;
      step     = ($urandom_range(3, 0) == 0);
      halt_req = ($urandom_range(24, 0) == 0);
      if (burst == 0 && $urandom_range(99, 0) < 2) burst = $urandom_range(20, 10);
      if (burst > 0) begin
        mem_wait = 1'b1;
        burst--;
      end else begin
        mem_wait = ($urandom_range(2, 0) == 0);
      end
      ticks(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
